// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ requesters.
// Optional frame watchdog built when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   req_data,
    input  logic [2*N_REQ-1:0]   req_sel,
    output logic [N_REQ-1:0]     gnt,
    output logic [N_REQ-1:0]     done,
    output logic                 TX_start,
    output logic [7:0]           TX_DATA,
    output logic [1:0]           sel,
    input  logic                 tx_busy,
    output logic                 timeout_err
);

    localparam int PTR_W = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_cfg_check
        $error("uart_tx_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;

    state_t             state, state_nxt;
    logic [PTR_W-1:0]   ptr, owner, owner_inc, win_idx;
    logic               win_found;
    logic               to_hit, to_fire;
    logic               load, adv_ptr, start_nxt;
    logic [N_REQ-1:0]   gnt_nxt, done_nxt;

    assign owner_inc = (owner == PTR_W'(N_REQ - 1)) ? '0 : owner + 1'b1;

    // First requester at or above ptr, wrapping around.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!win_found && req[(int'(ptr) + k) % N_REQ]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'((int'(ptr) + k) % N_REQ);
            end
        end
    end

    // A falling busy in WAIT_DONE wins over a simultaneous watchdog expiry.
    assign to_fire = to_hit && ((state == WAIT_BUSY) || (state == WAIT_DONE && tx_busy));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Busy is ignored while TX_start is still high, so the frame's own start cycle never counts.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (win_found) state_nxt = WAIT_BUSY;
            WAIT_BUSY: begin
                if (to_fire)                   state_nxt = IDLE;
                else if (tx_busy && !TX_start) state_nxt = WAIT_DONE;
            end
            WAIT_DONE: if (!tx_busy || to_fire) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gnt_nxt   = '0;
        done_nxt  = '0;
        start_nxt = 1'b0;
        load      = 1'b0;
        adv_ptr   = to_fire;
        case (state)
            IDLE: begin
                if (win_found) begin
                    load      = 1'b1;
                    start_nxt = 1'b1;
                    gnt_nxt   = N_REQ'(1) << win_idx;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    done_nxt = N_REQ'(1) << owner;
                    adv_ptr  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gnt      <= '0;
            done     <= '0;
            TX_start <= 1'b0;
            TX_DATA  <= 8'h00;
            sel      <= 2'b00;
            owner    <= '0;
            ptr      <= '0;
        end else begin
            gnt      <= gnt_nxt;
            done     <= done_nxt;
            TX_start <= start_nxt;
            if (load) begin
                owner   <= win_idx;
                TX_DATA <= req_data[8*int'(win_idx) +: 8];
                sel     <= req_sel[2*int'(win_idx) +: 2];
            end
            if (adv_ptr) ptr <= owner_inc;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYCLES);

    logic [15:0] to_cnt;

    // Restarts on entry to each wait phase, so each phase gets the full budget.
    always_ff @(posedge clk) begin
        if (reset)                                        to_cnt <= '0;
        else if (state_nxt != state && state_nxt != IDLE) to_cnt <= '0;
        else if (state != IDLE)                           to_cnt <= to_cnt + 1'b1;
    end

    assign to_hit = (state != IDLE) && (to_cnt == TO_LIM);

    always_ff @(posedge clk) begin
        if (reset) timeout_err <= 1'b0;
        else       timeout_err <= to_fire;
    end
`else
    assign to_hit      = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single UART transmitter among `N_REQ` requesters. Each requester presents a byte and a parity/mode select. The arbiter picks one winner, loads `TX_DATA`/`sel`, pulses `TX_start`, tracks the frame through the transmitter's busy flag, and returns a per-requester completion pulse. It sits between the client logic and `UART_Top`'s transmit inputs.

## Interface
- `N_REQ`, default 4: number of requesters, range 2–8.
- `TIMEOUT_CYCLES`, default 65535: watchdog limit per frame phase, only used with the macro in Configuration.
- `clk` in 1: system clock. One clock domain; all logic on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `req` in N_REQ: level request, one bit per requester.
- `req_data` in 8*N_REQ: byte for requester i, at bits [8i+7:8i].
- `req_sel` in 2*N_REQ: frame mode for requester i, at bits [2i+1:2i].
- `gnt` out N_REQ: one-hot, one-cycle pulse. Marks the cycle the request is accepted and its data latched.
- `done` out N_REQ: one-hot, one-cycle pulse. The owner's frame has left the transmitter.
- `TX_start` out 1: one-cycle start pulse to the transmitter.
- `TX_DATA` out 8: latched byte, held for the whole frame.
- `sel` out 2: latched frame mode, held for the whole frame.
- `tx_busy` in 1: transmitter busy flag.
- `timeout_err` out 1: one-cycle pulse on watchdog expiry.

## Operation
- States: IDLE, WAIT_BUSY, WAIT_DONE. Internal registers: `owner`, and `ptr` of width $clog2(N_REQ).
- IDLE, `req` != 0:
  - Winner = first set bit scanning from `ptr` upward, wrapping modulo N_REQ.
  - Next edge: `gnt[w]`<=1, `TX_start`<=1, `TX_DATA`<=req_data[w], `sel`<=req_sel[w], `owner`<=w, state<=WAIT_BUSY.
- IDLE, `req` == 0: stay in IDLE; all outputs except `TX_DATA`/`sel` are 0.
- WAIT_BUSY: `gnt` and `TX_start` return to 0. When `tx_busy`=1, go to WAIT_DONE.
- WAIT_DONE, `tx_busy`=0:
  - Next edge: `done[owner]`<=1, `ptr`<=(owner+1) mod N_REQ, state<=IDLE.
- Requester handshake:
  - Drop `req` in the cycle after `gnt`.
  - A `req` still high in IDLE is treated as a new request and is arbitrated fairly behind the others.
  - `req_data`/`req_sel` only need to be valid in the cycle the arbiter samples them (IDLE with `req` high).
- `req` changes during WAIT_* are ignored until the return to IDLE.
- `TX_DATA`/`sel` do not change between `gnt` and `done` of the same frame.
- Fairness: with all requesters held high, grants rotate 0,1,2,…,N_REQ-1,0. No requester waits more than N_REQ-1 frames.
- Reset (at any time, including mid-frame):
  - state=IDLE, `ptr`=0, `owner`=0.
  - `gnt`, `done`, `TX_start`, `timeout_err` = 0; `TX_DATA`=8'h00, `sel`=2'b00.
  - An aborted frame produces no `done`.

## Timing
- Request to grant:
  - `req` high at cycle 0 in IDLE → `gnt` and `TX_start` high in cycle 1 only.
  - `TX_DATA`/`sel` valid from cycle 1.
- `tx_busy` is sampled from cycle 2 onward. A `tx_busy` high already in cycle 1 is not seen until cycle 2.
- `tx_busy` falls at cycle k (in WAIT_DONE) → `done` high in cycle k+1; state is IDLE in cycle k+1.
- Back-to-back frames: `req` sampled in cycle k+1 → next `gnt`/`TX_start` in cycle k+2, giving a minimum 1 idle cycle between frames.
- Exactly one `TX_start` per `gnt`. `gnt` and `done` are never high in the same cycle.

## Configuration
- `UART_ARB_TIMEOUT_EN` defined:
  - A 16-bit counter clears on entry to WAIT_BUSY and on entry to WAIT_DONE, and increments every cycle in those states.
  - When it reaches `TIMEOUT_CYCLES`, the next edge sets `timeout_err`=1 for one cycle, state<=IDLE and `ptr`<=owner+1.
  - No `done` is issued for that frame.
- `UART_ARB_TIMEOUT_EN` undefined:
  - No counter is built and `timeout_err` is tied to 0.
  - The arbiter waits indefinitely in WAIT_BUSY/WAIT_DONE.

## Test plan
- Single request: `req`=4'b0100 (held 1 cycle), `req_data[23:16]`=8'hAA, `req_sel[5:4]`=2'b10; model `tx_busy` high for 10 cycles → `gnt`=4'b0100 and `TX_start`=1 in cycle 1, `TX_DATA`=8'hAA, `sel`=2'b10 until `done`=4'b0100 one cycle after `tx_busy` falls.
- Simultaneous requests: `req`=4'b1010 at reset release (`ptr`=0) → grant order 1 then 3; second `gnt` 1 cycle after the first `done`.
- Fairness: `req`=4'b1111 held continuously for 8 frames → grant sequence 0,1,2,3,0,1,2,3; exactly one `TX_start` per grant.
- Late busy: `tx_busy` rises 5 cycles after `TX_start` → arbiter stays in WAIT_BUSY; no `done` and no second `TX_start`; `done` after `tx_busy` falls.
- Reset mid-frame: assert `reset` while in WAIT_DONE → next cycle all outputs 0 and no `done`; a new `req`=4'b0001 is granted 1 cycle after `reset` drops.
- Timeout (`UART_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=20): `tx_busy` stuck 0 after grant to requester 2 → `timeout_err` pulse in cycle 22 with `done`=0; next grant starts the scan at requester 3.
